hls_stream_to_xillybus_rd: RTL and testbench

//  Return-path bridge: accepts 32-bit words from an HLS ap_fifo output port (din/full_n/write)
//  and presents them to the Xillybus read stream (rden/empty/data/eof/open) for /dev/xillybus_read_32.

---
 rtl/hls_xb_pkg.sv | 23 ++
 rtl/hls_xb_sdp_ram.sv | 42 ++++
 rtl/hls_stream_to_xillybus_rd.sv | 173 +++++++++++++++++
 tb/tb_hls_stream_to_xillybus_rd.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_xb_pkg.sv
// rtl/hls_xb_pkg.sv - shared defaults, width helpers and frame-state enum for the HLS-to-Xillybus read bridge
package hls_xb_pkg;

    localparam int DW_DEF          = 32;
    localparam int DEPTH_DEF       = 512;
    localparam int FRAME_WORDS_DEF = 1024;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the count can hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        FR_RUN     = 2'd0,
        FR_CLOSING = 2'd1,
        FR_EOF     = 2'd2
    } frame_state_e;

endpackage

// File: rtl/hls_xb_sdp_ram.sv
// rtl/hls_xb_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module hls_xb_sdp_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_rd,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Output register clears on reset and holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (rst_rd) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hls_stream_to_xillybus_rd.sv
// rtl/hls_stream_to_xillybus_rd.sv - HLS ap_fifo output to Xillybus read stream bridge with circular buffer
// Optional frame EOF logic enabled by defining HLS_RD_FRAME_EOF_EN.
module hls_stream_to_xillybus_rd
    import hls_xb_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic          bus_clk,
    input  logic          srst,
    input  logic [DW-1:0] out_arr_din,
    input  logic          out_arr_write,
    output logic          out_arr_full_n,
    input  logic          user_r_read_32_rden,
    output logic          user_r_read_32_empty,
    output logic [DW-1:0] user_r_read_32_data,
    output logic          user_r_read_32_eof,
    input  logic          user_r_read_32_open,
    output logic          ovf_err,
    output logic          udf_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_n_q, full_n_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          frame_hold_d;

    logic flush;
    logic wr_store;
    logic rd_ok;

    // A closed device drops everything but keeps accepting so the HLS core never stalls.
    assign flush    = srst || !user_r_read_32_open;
    assign wr_store = out_arr_write && full_n_q && !flush;
    assign rd_ok    = user_r_read_32_rden && !empty_q && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_store) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(wr_store) - CW'(rd_ok);
        end
    end

`ifdef HLS_RD_FRAME_EOF_EN
    localparam int FCW = $clog2(FRAME_WORDS + 1);

    frame_state_e   state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           eof_q, eof_d;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (flush) begin
            state_d = FR_RUN;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                FR_RUN: begin
                    if (wr_store) begin
                        fcnt_d = fcnt_q + FCW'(1);
                        if (fcnt_d == FCW'(FRAME_WORDS)) begin
                            state_d = FR_CLOSING;
                        end
                    end
                end
                FR_CLOSING: begin
                    if (count_d == '0) begin
                        state_d = FR_EOF;
                    end
                end
                FR_EOF: begin
                    state_d = FR_EOF;
                end
                default: begin
                    state_d = FR_RUN;
                end
            endcase
        end
        frame_hold_d = (state_d != FR_RUN);
        eof_d        = (state_d == FR_EOF);
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state_q <= FR_RUN;
            fcnt_q  <= '0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            eof_q   <= eof_d;
        end
    end

    assign user_r_read_32_eof = eof_q;
`else
    // Frame limit has no meaning when the block streams indefinitely.
    localparam int frame_words_unused = FRAME_WORDS;

    assign frame_hold_d       = 1'b0;
    assign user_r_read_32_eof = 1'b0;
`endif

    always_comb begin
        empty_d  = (count_d == '0);
        full_n_d = !user_r_read_32_open || ((count_d < DEPTH_C) && !frame_hold_d);
        ovf_d    = ovf_q || (out_arr_write && !full_n_q);
        udf_d    = udf_q || (user_r_read_32_rden && empty_q);
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_n_q <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_n_q <= full_n_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    hls_xb_sdp_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk    (bus_clk),
        .rst_rd (flush),
        .we     (wr_store),
        .waddr  (wr_ptr_q),
        .wdata  (out_arr_din),
        .re     (rd_ok),
        .raddr  (rd_ptr_q),
        .rdata  (user_r_read_32_data)
    );

    assign out_arr_full_n       = full_n_q;
    assign user_r_read_32_empty = empty_q;
    assign ovf_err              = ovf_q;
    assign udf_err              = udf_q;

endmodule

// File: tb/tb_hls_stream_to_xillybus_rd.sv
// tb/tb_hls_stream_to_xillybus_rd.sv - directed self-checking bench for hls_stream_to_xillybus_rd
module tb_hls_stream_to_xillybus_rd;

    logic        clk = 1'b0;
    logic        srst;
    logic        open;
    logic        write;
    logic        rden;
    logic [31:0] din;

    logic        sm_full_n, sm_empty, sm_eof, sm_ovf, sm_udf;
    logic [31:0] sm_data;
    logic        bg_full_n, bg_empty, bg_eof, bg_ovf, bg_udf;
    logic [31:0] bg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hls_stream_to_xillybus_rd #(.DW(32), .DEPTH(8)) u_sm (
        .bus_clk              (clk),
        .srst                 (srst),
        .out_arr_din          (din),
        .out_arr_write        (write),
        .out_arr_full_n       (sm_full_n),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_empty (sm_empty),
        .user_r_read_32_data  (sm_data),
        .user_r_read_32_eof   (sm_eof),
        .user_r_read_32_open  (open),
        .ovf_err              (sm_ovf),
        .udf_err              (sm_udf)
    );

    hls_stream_to_xillybus_rd #(.DW(32), .DEPTH(512)) u_bg (
        .bus_clk              (clk),
        .srst                 (srst),
        .out_arr_din          (din),
        .out_arr_write        (write),
        .out_arr_full_n       (bg_full_n),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_empty (bg_empty),
        .user_r_read_32_data  (bg_data),
        .user_r_read_32_eof   (bg_eof),
        .user_r_read_32_open  (open),
        .ovf_err              (bg_ovf),
        .udf_err              (bg_udf)
    );

`ifdef HLS_RD_FRAME_EOF_EN
    logic        fr_full_n, fr_empty, fr_eof, fr_ovf, fr_udf;
    logic [31:0] fr_data;

    hls_stream_to_xillybus_rd #(.DW(32), .DEPTH(8), .FRAME_WORDS(4)) u_fr (
        .bus_clk              (clk),
        .srst                 (srst),
        .out_arr_din          (din),
        .out_arr_write        (write),
        .out_arr_full_n       (fr_full_n),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_empty (fr_empty),
        .user_r_read_32_data  (fr_data),
        .user_r_read_32_eof   (fr_eof),
        .user_r_read_32_open  (open),
        .ovf_err              (fr_ovf),
        .udf_err              (fr_udf)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst  = 1'b1;
        open  = 1'b1;
        write = 1'b0;
        rden  = 1'b0;
        din   = '0;
        tick();
        tick();
        srst = 1'b0;
        tick();
    endtask

    initial begin
        srst  = 1'b1;
        open  = 1'b1;
        write = 1'b0;
        rden  = 1'b0;
        din   = '0;

        // 1: reset / idle
        repeat (3) tick();
        chk("rst_full_n_in_srst", {31'd0, sm_full_n}, 32'd0);
        srst = 1'b0;
        tick();
        chk("idle_full_n", {31'd0, sm_full_n}, 32'd1);
        chk("idle_empty", {31'd0, sm_empty}, 32'd1);
        chk("idle_eof", {31'd0, sm_eof}, 32'd0);
        chk("idle_data", sm_data, 32'd0);
        chk("idle_ovf", {31'd0, sm_ovf}, 32'd0);
        chk("idle_udf", {31'd0, sm_udf}, 32'd0);

        // 2: ordering through the deep buffer
        for (int i = 1; i <= 16; i++) begin
            din   = i;
            write = 1'b1;
            tick();
        end
        write = 1'b0;
        chk("ord_not_empty", {31'd0, bg_empty}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            rden = 1'b1;
            tick();
            chk($sformatf("ord_data_%0d", i), bg_data, i);
        end
        rden = 1'b0;
        tick();
        chk("ord_empty_after", {31'd0, bg_empty}, 32'd1);
        chk("ord_data_hold", bg_data, 32'h10);
        chk("ord_flags", {28'd0, bg_full_n, bg_eof, bg_ovf, bg_udf}, 32'b1000);

        // 3: full at DEPTH=8
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            din   = i;
            write = 1'b1;
            tick();
            if (i == 7) chk("full_n_after_7", {31'd0, sm_full_n}, 32'd1);
            if (i == 8) chk("full_n_after_8", {31'd0, sm_full_n}, 32'd0);
        end
        write = 1'b0;
        chk("full_ovf", {31'd0, sm_ovf}, 32'd1);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("full_rd1_data", sm_data, 32'd1);
        chk("full_n_after_read", {31'd0, sm_full_n}, 32'd1);
        for (int i = 2; i <= 8; i++) begin
            rden = 1'b1;
            tick();
            chk($sformatf("full_data_%0d", i), sm_data, i);
        end
        rden = 1'b0;
        chk("full_empty", {31'd0, sm_empty}, 32'd1);
        chk("full_udf_clear", {31'd0, sm_udf}, 32'd0);
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("udf_set", {31'd0, sm_udf}, 32'd1);
        chk("udf_data_hold", sm_data, 32'd8);

        // 4: wrap with simultaneous write and read
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            din   = i;
            write = 1'b1;
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            din   = 5 + i;
            write = 1'b1;
            rden  = 1'b1;
            tick();
            chk($sformatf("wrap_data_%0d", i), sm_data, 1 + i);
            chk($sformatf("wrap_flags_%0d", i), {30'd0, sm_empty, sm_full_n}, 32'b01);
        end
        write = 1'b0;
        rden  = 1'b0;
        tick();
        chk("wrap_errs", {30'd0, sm_ovf, sm_udf}, 32'd0);

        // 5: close mid-burst
        do_reset();
        for (int i = 0; i < 5; i++) begin
            din   = 32'h11 + i;
            write = 1'b1;
            tick();
        end
        open = 1'b0;
        din  = 32'h55;
        tick();
        chk("close_empty", {31'd0, sm_empty}, 32'd1);
        chk("close_full_n", {31'd0, sm_full_n}, 32'd1);
        chk("close_eof", {31'd0, sm_eof}, 32'd0);
        chk("close_data", sm_data, 32'd0);
        open = 1'b1;
        din  = 32'hAA;
        tick();
        write = 1'b0;
        tick();
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("reopen_first", sm_data, 32'hAA);
        chk("reopen_empty", {31'd0, sm_empty}, 32'd1);
        chk("reopen_ovf", {31'd0, sm_ovf}, 32'd0);

`ifdef HLS_RD_FRAME_EOF_EN
        // 6: frame EOF with FRAME_WORDS=4
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            din   = i;
            write = 1'b1;
            tick();
        end
        write = 1'b0;
        chk("frame_full_n_closed", {31'd0, fr_full_n}, 32'd0);
        tick();
        chk("frame_closing", {30'd0, fr_full_n, fr_eof}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            rden = 1'b1;
            tick();
            chk($sformatf("frame_data_%0d", i), fr_data, i);
        end
        rden = 1'b0;
        chk("frame_eof", {31'd0, fr_eof}, 32'd1);
        chk("frame_eof_empty", {31'd0, fr_empty}, 32'd1);
        tick();
        chk("frame_eof_held", {30'd0, fr_eof, fr_full_n}, 32'b10);
        open = 1'b0;
        tick();
        chk("frame_reopen_eof", {31'd0, fr_eof}, 32'd0);
        chk("frame_reopen_full_n", {31'd0, fr_full_n}, 32'd1);
        open = 1'b1;
        for (int i = 5; i <= 6; i++) begin
            din   = i;
            write = 1'b1;
            tick();
        end
        write = 1'b0;
        for (int i = 5; i <= 6; i++) begin
            rden = 1'b1;
            tick();
            chk($sformatf("frame_rest_%0d", i), fr_data, i);
        end
        rden = 1'b0;
        chk("frame_ovf", {31'd0, fr_ovf}, 32'd0);
        chk("frame_udf", {31'd0, fr_udf}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
